// File: rtl/ibex_irq_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: FSM state encodings and ID sizing.
// Used by ibex_irq_arbiter and ibex_irq_prio_enc.
package ibex_irq_arbiter_pkg;

    localparam int unsigned IRQ_ID_W    = 5;
    localparam int unsigned IRQ_MAX     = 32;
    localparam int unsigned IRQ_STATE_W = 2;

    localparam logic [IRQ_STATE_W-1:0] IRQ_IDLE = 2'd0;
    localparam logic [IRQ_STATE_W-1:0] IRQ_REQ  = 2'd1;
    localparam logic [IRQ_STATE_W-1:0] IRQ_WAIT = 2'd2;

endpackage

// File: rtl/ibex_irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder over NUM_IRQ request lines.
// Produces a valid flag and the 5-bit index of the winning line.
module ibex_irq_prio_enc
    import ibex_irq_arbiter_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 16
) (
    input  logic [NUM_IRQ-1:0]  req,
    output logic                valid_c,
    output logic [IRQ_ID_W-1:0] id_c
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid_c = 1'b0;
        id_c    = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid_c = 1'b1;
                id_c    = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/ibex_irq_arbiter.sv
// Interrupt source arbiter: pending register, masking, fixed-priority selection and
// a request/ack handshake to the core controller. Define IBEX_IRQ_EDGE_EN for edge mode.
module ibex_irq_arbiter
    import ibex_irq_arbiter_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_lines_i,
    input  logic [NUM_IRQ-1:0]  irq_enable_i,
    input  logic                irq_ack_i,
    input  logic [IRQ_ID_W-1:0] irq_id_i,
    output logic                irq_req_ctrl_o,
    output logic [IRQ_ID_W-1:0] irq_id_ctrl_o,
    output logic                irq_o,
    output logic [NUM_IRQ-1:0]  pending_o,
    output logic                ack_err_o
);

    logic [IRQ_STATE_W-1:0] state_q, state_d;
    logic [NUM_IRQ-1:0]     pending_q, pending_d, eligible;
    logic                   enc_valid;
    logic [IRQ_ID_W-1:0]    enc_id;
    logic                   ack_match;
    logic                   req_d;
    logic [IRQ_ID_W-1:0]    id_d;
    logic                   err_d;

    assign eligible  = pending_q & irq_enable_i;
    assign irq_o     = |eligible;
    assign pending_o = pending_q;
    // The presented ID is always below NUM_IRQ, so out-of-range acks can never match.
    assign ack_match = irq_ack_i && (irq_id_i == irq_id_ctrl_o);

    ibex_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .req     (eligible),
        .valid_c (enc_valid),
        .id_c    (enc_id)
    );

`ifdef IBEX_IRQ_EDGE_EN
    localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

    logic [NUM_IRQ-1:0] hist_q;
    logic [NUM_IRQ-1:0] clr;

    // History tracks the lines through reset too, so a line held high is not an edge.
    always_ff @(posedge clk) begin
        hist_q <= irq_lines_i;
    end

    // Sticky pending bits; a fresh rising edge wins over a same-cycle clear.
    always_comb begin
        clr = '0;
        if ((state_q == IRQ_REQ) && ack_match) begin
            clr = ONE << irq_id_ctrl_o;
        end
        pending_d = (pending_q & ~clr) | (irq_lines_i & ~hist_q);
    end
`else
    assign pending_d = irq_lines_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IRQ_IDLE;
            irq_req_ctrl_o <= 1'b0;
            irq_id_ctrl_o  <= '0;
            ack_err_o      <= 1'b0;
        end else begin
            state_q        <= state_d;
            irq_req_ctrl_o <= req_d;
            irq_id_ctrl_o  <= id_d;
            ack_err_o      <= err_d;
        end
    end

    // Next-state and next-output logic; no preemption once a request is presented.
    always_comb begin
        state_d = state_q;
        req_d   = irq_req_ctrl_o;
        id_d    = irq_id_ctrl_o;
        err_d   = 1'b0;
        case (state_q)
            IRQ_IDLE: begin
                err_d = irq_ack_i;
                if (enc_valid) begin
                    req_d   = 1'b1;
                    id_d    = enc_id;
                    state_d = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                if (ack_match) begin
                    req_d   = 1'b0;
                    state_d = IRQ_WAIT;
                end else begin
                    err_d = irq_ack_i;
                end
            end
            IRQ_WAIT: begin
                err_d   = irq_ack_i;
                state_d = IRQ_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IRQ_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ibex_irq_arbiter.sv
// Self-checking bench for ibex_irq_arbiter (NUM_IRQ=16); expectations follow
// IBEX_IRQ_EDGE_EN the same way the design does.
module tb_ibex_irq_arbiter;

    localparam int unsigned N = 16;
    localparam logic [N-1:0] ALL = 16'hFFFF;

    typedef struct {
        logic        req;
        logic [4:0]  id;
        logic        irq;
        logic [15:0] pend;
        logic        err;
        string       name;
    } exp_t;

    typedef struct {
        logic        rst;
        logic [15:0] lines;
        logic [15:0] en;
        logic        ack;
        logic [4:0]  aid;
        exp_t        exp;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [N-1:0]  irq_lines_i;
    logic [N-1:0]  irq_enable_i;
    logic          irq_ack_i;
    logic [4:0]    irq_id_i;
    logic          irq_req_ctrl_o;
    logic [4:0]    irq_id_ctrl_o;
    logic          irq_o;
    logic [N-1:0]  pending_o;
    logic          ack_err_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[17];

    ibex_irq_arbiter #(
        .NUM_IRQ (N)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_lines_i    (irq_lines_i),
        .irq_enable_i   (irq_enable_i),
        .irq_ack_i      (irq_ack_i),
        .irq_id_i       (irq_id_i),
        .irq_req_ctrl_o (irq_req_ctrl_o),
        .irq_id_ctrl_o  (irq_id_ctrl_o),
        .irq_o          (irq_o),
        .pending_o      (pending_o),
        .ack_err_o      (ack_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ex(input logic req, input logic [4:0] id, input logic irq,
                                input logic [15:0] pend, input logic err, input string nm);
        exp_t e;
        e.req = req; e.id = id; e.irq = irq; e.pend = pend; e.err = err; e.name = nm;
        return e;
    endfunction

    function automatic vec_t v(input logic r, input logic [15:0] l, input logic [15:0] en,
                               input logic a, input logic [4:0] aid, input exp_t e);
        vec_t t;
        t.rst = r; t.lines = l; t.en = en; t.ack = a; t.aid = aid; t.exp = e;
        return t;
    endfunction

    task automatic check(input exp_t e);
        checks++;
        if (irq_req_ctrl_o !== e.req || irq_id_ctrl_o !== e.id || irq_o !== e.irq ||
            pending_o !== e.pend || ack_err_o !== e.err) begin
            errors++;
            $display("FAIL %s: got req=%0b id=%0d irq=%0b pend=%h err=%0b, want req=%0b id=%0d irq=%0b pend=%h err=%0b",
                     e.name, irq_req_ctrl_o, irq_id_ctrl_o, irq_o, pending_o, ack_err_o,
                     e.req, e.id, e.irq, e.pend, e.err);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic step(input logic r, input logic [15:0] l, input logic [15:0] en,
                        input logic a, input logic [4:0] aid, input exp_t e);
        rst          = r;
        irq_lines_i  = l;
        irq_enable_i = en;
        irq_ack_i    = a;
        irq_id_i     = aid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(sb.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq_lines_i = '0; irq_enable_i = ALL; irq_ack_i = 1'b0; irq_id_i = '0;

        // Lines 3 and 7 held high across reset.
        step(1, 16'h0088, ALL, 0, 0, ex(0, 0, 0, 16'h0000, 0, "rst_hold0"));
        step(1, 16'h0088, ALL, 0, 0, ex(0, 0, 0, 16'h0000, 0, "rst_hold1"));
`ifdef IBEX_IRQ_EDGE_EN
        step(0, 16'h0088, ALL, 0, 0, ex(0, 0, 0, 16'h0000, 0, "rst_rel0"));
        step(0, 16'h0088, ALL, 0, 0, ex(0, 0, 0, 16'h0000, 0, "rst_rel1"));
        step(0, 16'h0000, ALL, 0, 0, ex(0, 0, 0, 16'h0000, 0, "rst_rel2"));
        step(0, 16'h0000, ALL, 0, 0, ex(0, 0, 0, 16'h0000, 0, "rst_rel3"));
`else
        step(0, 16'h0088, ALL, 0, 0, ex(0, 0, 1, 16'h0088, 0, "rst_rel0"));
        step(0, 16'h0088, ALL, 0, 0, ex(1, 3, 1, 16'h0088, 0, "rst_rel1"));
        step(0, 16'h0000, ALL, 1, 3, ex(0, 3, 0, 16'h0000, 0, "rst_rel_ack3"));
        step(0, 16'h0000, ALL, 0, 0, ex(0, 3, 0, 16'h0000, 0, "rst_rel_wait"));
`endif
        step(1, 16'h0000, ALL, 0, 0, ex(0, 0, 0, 16'h0000, 0, "rst_again"));
        step(0, 16'h0000, ALL, 0, 0, ex(0, 0, 0, 16'h0000, 0, "rst_clean"));

        // Priority, retire/cooldown, mismatched and out-of-range acks, stray acks.
        tbl[0]  = v(0, 16'h0204, ALL, 0, 0,  ex(0, 0, 1, 16'h0204, 0, "b_rise_9_2"));
        tbl[1]  = v(0, 16'h0204, ALL, 0, 0,  ex(1, 2, 1, 16'h0204, 0, "b_req2"));
        tbl[2]  = v(0, 16'h0204, ALL, 0, 0,  ex(1, 2, 1, 16'h0204, 0, "b_hold2"));
        tbl[3]  = v(0, 16'h0200, ALL, 1, 2,  ex(0, 2, 1, 16'h0200, 0, "b_ack2"));
        tbl[4]  = v(0, 16'h0200, ALL, 0, 0,  ex(0, 2, 1, 16'h0200, 0, "b_gap2"));
        tbl[5]  = v(0, 16'h0200, ALL, 0, 0,  ex(1, 9, 1, 16'h0200, 0, "b_req9"));
        tbl[6]  = v(0, 16'h0000, ALL, 1, 9,  ex(0, 9, 0, 16'h0000, 0, "b_ack9"));
        tbl[7]  = v(0, 16'h0000, ALL, 0, 0,  ex(0, 9, 0, 16'h0000, 0, "b_idle"));
        tbl[8]  = v(0, 16'h0020, ALL, 0, 0,  ex(0, 9, 1, 16'h0020, 0, "c_rise5"));
        tbl[9]  = v(0, 16'h0020, ALL, 0, 0,  ex(1, 5, 1, 16'h0020, 0, "c_req5"));
        tbl[10] = v(0, 16'h0020, ALL, 1, 6,  ex(1, 5, 1, 16'h0020, 1, "c_ack6_err"));
        tbl[11] = v(0, 16'h0020, ALL, 0, 0,  ex(1, 5, 1, 16'h0020, 0, "c_err_1cyc"));
        tbl[12] = v(0, 16'h0020, ALL, 1, 20, ex(1, 5, 1, 16'h0020, 1, "c_ack20_err"));
        tbl[13] = v(0, 16'h0000, ALL, 1, 5,  ex(0, 5, 0, 16'h0000, 0, "c_ack5"));
        tbl[14] = v(0, 16'h0000, ALL, 1, 0,  ex(0, 5, 0, 16'h0000, 1, "c_ack_in_wait"));
        tbl[15] = v(0, 16'h0000, ALL, 1, 0,  ex(0, 5, 0, 16'h0000, 1, "c_ack_in_idle"));
        tbl[16] = v(0, 16'h0000, ALL, 0, 0,  ex(0, 5, 0, 16'h0000, 0, "c_quiet"));
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst, tbl[i].lines, tbl[i].en, tbl[i].ack, tbl[i].aid, tbl[i].exp);
        end

        // Line 4 active again at the moment its ack is sampled.
        step(0, 16'h0010, ALL, 0, 0, ex(0, 5, 1, 16'h0010, 0, "e_rise4"));
`ifdef IBEX_IRQ_EDGE_EN
        step(0, 16'h0000, ALL, 0, 0, ex(1, 4, 1, 16'h0010, 0, "e_req4_sticky"));
`else
        step(0, 16'h0010, ALL, 0, 0, ex(1, 4, 1, 16'h0010, 0, "e_req4"));
`endif
        step(0, 16'h0010, ALL, 1, 4, ex(0, 4, 1, 16'h0010, 0, "e_ack4_reset"));
        step(0, 16'h0010, ALL, 0, 0, ex(0, 4, 1, 16'h0010, 0, "e_gap"));
        step(0, 16'h0010, ALL, 0, 0, ex(1, 4, 1, 16'h0010, 0, "e_req4_again"));
`ifdef IBEX_IRQ_EDGE_EN
        step(0, 16'h0010, ALL, 1, 4, ex(0, 4, 0, 16'h0000, 0, "e_ack4_clear"));
`else
        step(0, 16'h0000, ALL, 1, 4, ex(0, 4, 0, 16'h0000, 0, "e_ack4_clear"));
`endif
        step(0, 16'h0000, ALL, 0, 0, ex(0, 4, 0, 16'h0000, 0, "e_wait"));
        step(0, 16'h0000, ALL, 0, 0, ex(0, 4, 0, 16'h0000, 0, "e_idle"));

        // Masked pending line, then unmask, then reset in the middle of the request.
        step(0, 16'h0002, 16'hFFFD, 0, 0, ex(0, 4, 0, 16'h0002, 0, "d_masked0"));
        step(0, 16'h0002, 16'hFFFD, 0, 0, ex(0, 4, 0, 16'h0002, 0, "d_masked1"));
        step(0, 16'h0002, ALL,      0, 0, ex(1, 1, 1, 16'h0002, 0, "d_unmask_req1"));
        step(1, 16'h0002, ALL,      0, 0, ex(0, 0, 0, 16'h0000, 0, "d_rst_mid_req"));
`ifdef IBEX_IRQ_EDGE_EN
        step(0, 16'h0002, ALL,      0, 0, ex(0, 0, 0, 16'h0000, 0, "d_post_rst0"));
        step(0, 16'h0002, ALL,      0, 0, ex(0, 0, 0, 16'h0000, 0, "d_post_rst1"));
`else
        step(0, 16'h0002, ALL,      0, 0, ex(0, 0, 1, 16'h0002, 0, "d_post_rst0"));
        step(0, 16'h0002, ALL,      0, 0, ex(1, 1, 1, 16'h0002, 0, "d_post_rst1"));
`endif

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_irq_arbiter.md
# ibex_irq_arbiter

Interrupt source side of the core's interrupt handshake. It collects external interrupt lines, holds them in a pending register, masks them, and arbitrates them by fixed priority. It presents one request/ID pair to the core controller and retires it when the controller acknowledges it. It sits between the platform interrupt lines and the controller's irq_i / irq_req_ctrl_i / irq_id_ctrl_i inputs and irq_ack_o / irq_id_o outputs.

## Interface
- NUM_IRQ, default 16: number of interrupt lines, range 1..32; the ID is always 5 bits.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset. Synchronous and active-high. Single clock domain.
- irq_lines_i  in  NUM_IRQ  external interrupt lines, already synchronous to clk.
- irq_enable_i  in  NUM_IRQ  per-line mask (1 = enabled).
- irq_ack_i  in  1  acknowledge pulse from the controller.
- irq_id_i  in  5  ID being acknowledged; valid with irq_ack_i.
- irq_req_ctrl_o  out  1  request to the controller (registered).
- irq_id_ctrl_o  out  5  ID of the presented request (registered).
- irq_o  out  1  any enabled pending interrupt; used by the controller to wake from sleep.
- pending_o  out  NUM_IRQ  pending register, for CSR readback.
- ack_err_o  out  1  one-cycle pulse when an acknowledge is rejected.

## Operation
- pending_q: NUM_IRQ-bit register. Its update rule is set by Configuration.
- Eligible set: pending_q & irq_enable_i. The lowest index has the highest priority.
- irq_o is combinational: it is the OR of the eligible set. It ignores FSM state.
- The FSM has three states: IDLE, REQ, WAIT.
  - IDLE: if the eligible set is non-zero, latch the winner into irq_id_ctrl_o, set irq_req_ctrl_o, and go to REQ.
  - REQ: hold irq_req_ctrl_o=1 and irq_id_ctrl_o stable. Ignore later mask changes and higher-priority arrivals; there is no preemption.
  - REQ, on irq_ack_i with irq_id_i == irq_id_ctrl_o: clear irq_req_ctrl_o and go to WAIT.
  - REQ, on irq_ack_i with a mismatched ID: pulse ack_err_o, stay in REQ, leave pending_q unchanged.
  - WAIT: one-cycle cooldown, then go to IDLE. WAIT prevents a level source that has not yet dropped from being re-presented back-to-back.
- irq_ack_i in IDLE or WAIT: pulse ack_err_o; no other effect.
- IDs at or above NUM_IRQ are never presented. Acknowledging such an ID is treated as a mismatch.
- Reset values:
  - pending_q=0.
  - irq_req_ctrl_o=0, irq_id_ctrl_o=0, ack_err_o=0.
  - FSM=IDLE.
  - Edge-history register loads irq_lines_i.
  - Consequence: irq_o=0 and pending_o=0 while rst is held.
- Reset mid-request drops the request with no acknowledge required. A source that is still active is re-presented after reset only in level mode.

## Timing
- A line asserting at edge N sets pending_q at N+1 and irq_req_ctrl_o at N+2 (IDLE case).
- irq_o follows pending_q in the same cycle.
- A valid ack sampled at edge M gives irq_req_ctrl_o=0 at M+1 and WAIT during M+1.
- The earliest next request is irq_req_ctrl_o=1 at M+2.
- Sustained throughput: one interrupt per 3 cycles plus controller ack latency.
- Simultaneous set and clear on the same bit in the same cycle: set wins (a new event is never lost).

## Configuration
- IBEX_IRQ_EDGE_EN defined (edge mode):
  - A pending bit sets on a 0→1 transition of irq_lines_i against the history register.
  - The bit is sticky. It clears only on a valid ack of that ID, at M+1.
  - Masked lines still latch their edges.
- IBEX_IRQ_EDGE_EN undefined (level mode):
  - pending_q <= irq_lines_i every cycle.
  - A valid ack does not clear pending_q; the handler must quiesce the source.
  - The edge-history register is not built.

## Structure
- Shared package holds:
  - state localparams IRQ_IDLE=0, IRQ_REQ=1, IRQ_WAIT=2 (2-bit);
  - IRQ_ID_W=5;
  - IRQ_MAX=32.
- One sub-module: ibex_irq_prio_enc. It is a purely combinational NUM_IRQ-wide lowest-index priority encoder with valid and 5-bit ID outputs.
- The FSM, pending register and edge logic stay in the top module.

## Test plan
- Reset while lines 3 and 7 are high, then release. Level mode: request with ID 3 two cycles later. Edge mode: no request, pending_o=0.
- Lines 9 and 2 rise in the same cycle. Request shows ID 2. After ack(2), the request drops for two cycles, then returns with ID 9.
- In REQ for ID 5: ack with ID 6. ack_err_o pulses for exactly one cycle; the request holds ID 5. Then ack(5) retires it.
- Edge mode: line 4 re-rises in the same cycle ack(4) is sampled. pending_o[4] stays 1 and ID 4 is presented again at M+2.
- irq_enable_i=0 with line 1 pending. irq_o=0 and no request. Enable it: request ID 1 on the following edge. Then assert rst mid-REQ: all outputs return to 0 next cycle.
